router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_fsm_if.sv | 38 +++
 rtl/router_fsm.sv | 112 +++++++++++
 tb/tb_router_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Handshake bundle between the packet source/register block and the router control FSM.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: steers one packet at a time into output FIFO 0..2.
// Outputs are registered from the next state, so they always match the current state.
module router_fsm (
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       emptyIn, emptySel, softSel;
  logic       detectAdd_q, lfdState_q, ldState_q, lafState_q;
  logic       fullState_q, rstIntReg_q, writeEnb_q, busy_q;

  // emptyIn follows the incoming header; emptySel/softSel follow the latched address
  always_comb begin
    emptyIn  = 1'b0;
    emptySel = 1'b0;
    softSel  = 1'b0;
    case (bus.data_in)
      2'd0:    emptyIn = bus.fifo_empty_0;
      2'd1:    emptyIn = bus.fifo_empty_1;
      2'd2:    emptyIn = bus.fifo_empty_2;
      default: emptyIn = 1'b0;
    endcase
    case (addr_q)
      2'd0:    begin emptySel = bus.fifo_empty_0; softSel = bus.soft_reset_0; end
      2'd1:    begin emptySel = bus.fifo_empty_1; softSel = bus.soft_reset_1; end
      2'd2:    begin emptySel = bus.fifo_empty_2; softSel = bus.soft_reset_2; end
      default: begin emptySel = 1'b0;             softSel = 1'b0;             end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && bus.pkt_valid) addr_d = bus.data_in;
    if (softSel) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (bus.pkt_valid && bus.data_in != 2'd3)
            state_d = emptyIn ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (emptySel) state_d = LOAD_FIRST_DATA;
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= DECODE_ADDRESS;
      addr_q      <= 2'd0;
      detectAdd_q <= 1'b1;
      lfdState_q  <= 1'b0;
      ldState_q   <= 1'b0;
      lafState_q  <= 1'b0;
      fullState_q <= 1'b0;
      rstIntReg_q <= 1'b0;
      writeEnb_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      detectAdd_q <= (state_d == DECODE_ADDRESS);
      lfdState_q  <= (state_d == LOAD_FIRST_DATA);
      ldState_q   <= (state_d == LOAD_DATA);
      lafState_q  <= (state_d == LOAD_AFTER_FULL);
      fullState_q <= (state_d == FIFO_FULL_STATE);
      rstIntReg_q <= (state_d == CHECK_PARITY_ERROR);
      writeEnb_q  <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                     (state_d == LOAD_AFTER_FULL);
      busy_q      <= !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
    end
  end

  assign bus.detect_add    = detectAdd_q;
  assign bus.lfd_state     = lfdState_q;
  assign bus.ld_state      = ldState_q;
  assign bus.laf_state     = lafState_q;
  assign bus.full_state    = fullState_q;
  assign bus.rst_int_reg   = rstIntReg_q;
  assign bus.write_enb_reg = writeEnb_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each driven cycle queues the expected output
// vector {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}, popped after the edge.
module tb_router_fsm;

  typedef enum int {ExpDA, ExpLFD, ExpLD, ExpLAF, ExpFULL, ExpLP, ExpCPE, ExpWTE} expState_t;

  logic clock;
  logic resetn;
  int   assertCount;
  int   failCount;
  logic [7:0] expQ[$];
  string      tagQ[$];

  router_fsm_if bus();

  router_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] expOf(input expState_t s);
    case (s)
      ExpDA:   return 8'b1000_0000;
      ExpLFD:  return 8'b0100_0001;
      ExpLD:   return 8'b0010_0010;
      ExpLAF:  return 8'b0001_0011;
      ExpFULL: return 8'b0000_1001;
      ExpLP:   return 8'b0000_0011;
      ExpCPE:  return 8'b0000_0101;
      default: return 8'b0000_0001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic sampleDut();
    logic [7:0] observed;
    logic [7:0] expected;
    string      tag;
    observed = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_underflow", observed, 8'hxx);
    end else begin
      expected = expQ.pop_front();
      tag      = tagQ.pop_front();
      checkOutput(tag, observed, expected);
    end
  endtask

  // Inputs are already set; queue what the DUT must show after this edge, then sample it.
  task automatic applyStimulus(input string tag, input expState_t s);
    expQ.push_back(expOf(s));
    tagQ.push_back(tag);
    @(posedge clock);
    #1;
    sampleDut();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    resetn            = 1'b0;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;

    applyStimulus("reset", ExpDA);
    applyStimulus("reset_hold", ExpDA);
    resetn = 1'b1;
    applyStimulus("idle", ExpDA);

    // Normal packet to FIFO 1: 15 valid cycles then parity
    bus.data_in   = 2'd1;
    bus.pkt_valid = 1'b1;
    for (int i = 0; i < 15; i++)
      applyStimulus(i == 0 ? "norm_lfd" : "norm_ld", i == 0 ? ExpLFD : ExpLD);
    bus.pkt_valid = 1'b0;
    applyStimulus("norm_lp", ExpLP);
    applyStimulus("norm_cpe", ExpCPE);
    applyStimulus("norm_da", ExpDA);

    // FIFO 2 busy for 5 cycles; header changes mid-wait must not matter
    bus.data_in      = 2'd2;
    bus.fifo_empty_2 = 1'b0;
    bus.pkt_valid    = 1'b1;
    applyStimulus("wait_enter", ExpWTE);
    bus.data_in = 2'd0;
    for (int i = 0; i < 4; i++) applyStimulus("wait_hold", ExpWTE);
    bus.fifo_empty_2 = 1'b1;
    applyStimulus("wait_lfd", ExpLFD);
    applyStimulus("wait_ld", ExpLD);
    bus.pkt_valid = 1'b0;
    applyStimulus("wait_lp", ExpLP);
    applyStimulus("wait_cpe", ExpCPE);
    applyStimulus("wait_da", ExpDA);

    // Full stall then low_pkt_valid into parity
    bus.data_in   = 2'd0;
    bus.pkt_valid = 1'b1;
    applyStimulus("full_lfd", ExpLFD);
    applyStimulus("full_ld", ExpLD);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("full_stall", ExpFULL);
    bus.fifo_full = 1'b0;
    applyStimulus("full_laf", ExpLAF);
    bus.pkt_valid     = 1'b0;
    bus.low_pkt_valid = 1'b1;
    applyStimulus("laf_lp", ExpLP);
    bus.low_pkt_valid = 1'b0;
    applyStimulus("laf_cpe", ExpCPE);
    applyStimulus("laf_da", ExpDA);

    // LOAD_AFTER_FULL default back to LOAD_DATA, then parity_done exit
    bus.pkt_valid = 1'b1;
    applyStimulus("laf2_lfd", ExpLFD);
    applyStimulus("laf2_ld", ExpLD);
    bus.fifo_full = 1'b1;
    applyStimulus("laf2_full", ExpFULL);
    bus.fifo_full = 1'b0;
    applyStimulus("laf2_laf", ExpLAF);
    applyStimulus("laf2_back_ld", ExpLD);
    bus.fifo_full = 1'b1;
    applyStimulus("laf2_full2", ExpFULL);
    bus.fifo_full   = 1'b0;
    bus.pkt_valid   = 1'b0;
    applyStimulus("laf2_laf2", ExpLAF);
    bus.parity_done = 1'b1;
    applyStimulus("laf2_pdone", ExpDA);
    bus.parity_done = 1'b0;

    // Parity check with FIFO full goes to stall
    bus.data_in   = 2'd1;
    bus.pkt_valid = 1'b1;
    applyStimulus("cpe_lfd", ExpLFD);
    applyStimulus("cpe_ld", ExpLD);
    bus.pkt_valid = 1'b0;
    applyStimulus("cpe_lp", ExpLP);
    bus.fifo_full = 1'b1;
    applyStimulus("cpe_cpe", ExpCPE);
    applyStimulus("cpe_full", ExpFULL);
    bus.fifo_full = 1'b0;
    applyStimulus("cpe_laf", ExpLAF);
    bus.parity_done = 1'b1;
    applyStimulus("cpe_da", ExpDA);
    bus.parity_done = 1'b0;

    // Soft reset: only the latched FIFO's soft reset aborts
    bus.data_in   = 2'd0;
    bus.pkt_valid = 1'b1;
    applyStimulus("soft_lfd", ExpLFD);
    applyStimulus("soft_ld", ExpLD);
    bus.soft_reset_2 = 1'b1;
    applyStimulus("soft_other", ExpLD);
    bus.soft_reset_2 = 1'b0;
    bus.soft_reset_0 = 1'b1;
    bus.pkt_valid    = 1'b0;
    applyStimulus("soft_match", ExpDA);
    bus.soft_reset_0 = 1'b0;
    applyStimulus("soft_idle", ExpDA);

    // Invalid address 3 is ignored
    bus.data_in   = 2'd3;
    bus.pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus("invalid_addr", ExpDA);
    bus.pkt_valid = 1'b0;

    // Reset mid-packet aborts with no further writes
    bus.data_in   = 2'd1;
    bus.pkt_valid = 1'b1;
    applyStimulus("rst_lfd", ExpLFD);
    applyStimulus("rst_ld", ExpLD);
    resetn = 1'b0;
    applyStimulus("rst_mid", ExpDA);
    resetn        = 1'b1;
    bus.pkt_valid = 1'b0;
    applyStimulus("rst_after", ExpDA);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
